// File: rtl/prince_affine_layer_masked_pkg.sv
// Shared types and constants for the masked PRINCE affine layer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prince_affine_layer_masked_pkg;

    localparam int NIB_W   = 4;
    localparam int NIBBLES = 16;

    // Affine constants, added to share 0 only, after the linear part.
    localparam logic [NIB_W-1:0] A_CONST    = 4'h5;
    localparam logic [NIB_W-1:0] AINV_CONST = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

endpackage

// File: rtl/prince_affine_layer_masked_if.sv
// Handshake bundle for the masked affine layer: input state/mask and output state.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface prince_affine_layer_masked_if #(
    parameter int NSHARES = 2
);
    logic                      mode_i;
    logic                      in_valid;
    logic                      in_ready;
    logic [64*NSHARES-1:0]     state_i;
    logic [64*(NSHARES-1)-1:0] rnd_i;
    logic                      out_valid;
    logic                      out_ready;
    logic [64*NSHARES-1:0]     state_o;

    modport master (
        output mode_i, in_valid, state_i, rnd_i, out_ready,
        input  in_ready, out_valid, state_o
    );

    modport slave (
        input  mode_i, in_valid, state_i, rnd_i, out_ready,
        output in_ready, out_valid, state_o
    );
endinterface

// File: rtl/prince_affine_layer_masked_nibble.sv
// One nibble of PRINCE affine layer A or A^-1 for a single share.
// Latency: combinational.
// Backpressure: none (pure function).
module prince_affine_nibble
    import prince_affine_layer_masked_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             mode_i,
    input  logic             is_share0_i,
    output logic [NIB_W-1:0] nib_o
);

    logic [NIB_W-1:0] lin;

    // Linear part selected by mode; only share 0 receives the affine constant.
    always_comb begin
        lin   = '0;
        nib_o = '0;
        if (!mode_i) begin
            lin = {nib_i[2], nib_i[3], nib_i[0] ^ nib_i[1] ^ nib_i[2], nib_i[1]};
        end else begin
            lin = {nib_i[2], nib_i[3], nib_i[0], nib_i[0] ^ nib_i[1] ^ nib_i[3]};
        end
        nib_o = lin;
        if (is_share0_i) begin
            nib_o = lin ^ (mode_i ? AINV_CONST : A_CONST);
        end
    end

endmodule

// File: rtl/prince_affine_layer_masked.sv
// Masked PRINCE affine layer (A / A^-1), LANES nibbles of every share per cycle.
// Latency: out_valid rises 16/LANES+1 cycles after the input handshake cycle.
// Backpressure: result held in DONE until out_ready; no input accepted until back in IDLE.
module prince_affine_layer_masked
    import prince_affine_layer_masked_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int LANES   = 4,
    parameter int REFRESH = 0
) (
    input  logic clk,
    input  logic rst_n,
    prince_affine_layer_masked_if.slave bus
);

    localparam int STEPS = NIBBLES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SW    = 64 * NSHARES;

    if ((LANES < 1) || ((NIBBLES % LANES) != 0) || (NSHARES < 2)) begin : g_bad_param
        $error("prince_affine_layer_masked: LANES must divide 16 and NSHARES must be >= 2");
    end

    fsm_t            fsm_q, fsm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [SW-1:0]   dat_q, dat_d;

    logic [SW-1:0]   load_val;
    logic [63:0]     rnd_x;
    logic [SW-1:0]   busy_val;
    logic [3:0]      nib_base;
    logic [5:0]      lane_off [LANES];

    // Bit offset of each lane's nibble for the current step.
    always_comb begin
        nib_base = 4'(32'(cnt_q) * LANES);
        for (int l = 0; l < LANES; l++) begin
            lane_off[l] = {nib_base + 4'(l), 2'b00};
        end
    end

    // Value written on load: optional re-mask keeping the XOR of all shares unchanged.
    always_comb begin
        rnd_x    = '0;
        load_val = bus.state_i;
        for (int k = 1; k < NSHARES; k++) begin
            rnd_x = rnd_x ^ bus.rnd_i[64*(k-1) +: 64];
        end
        if (REFRESH != 0) begin
            load_val[63:0] = bus.state_i[63:0] ^ rnd_x;
            for (int k = 1; k < NSHARES; k++) begin
                load_val[64*k +: 64] = bus.state_i[64*k +: 64] ^ bus.rnd_i[64*(k-1) +: 64];
            end
        end
    end

    for (genvar k = 0; k < NSHARES; k++) begin : g_share
        logic [63:0] cur;
        logic [63:0] nxt;
        logic [3:0]  lane_res [LANES];

        assign cur = dat_q[64*k +: 64];

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            prince_affine_nibble u_nib (
                .nib_i       (cur[lane_off[l] +: 4]),
                .mode_i      (mode_q),
                .is_share0_i ((k == 0) ? 1'b1 : 1'b0),
                .nib_o       (lane_res[l])
            );
        end

        // Write the transformed lanes back in place; other nibbles of this share untouched.
        always_comb begin
            nxt = cur;
            for (int l = 0; l < LANES; l++) begin
                nxt[lane_off[l] +: 4] = lane_res[l];
            end
        end

        assign busy_val[64*k +: 64] = nxt;
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        fsm_d         = fsm_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        dat_d         = dat_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    dat_d  = load_val;
                    mode_d = bus.mode_i;
                    cnt_d  = '0;
                    fsm_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                dat_d = busy_val;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any partially processed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= ST_IDLE;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dat_q  <= dat_d;
        end
    end

    assign bus.state_o = dat_q;

endmodule

// File: tb/tb_prince_affine_layer_masked.sv
// Directed and random checks of the masked affine layer (plain and re-masking instances).
// Latency: checks 5-cycle handshake-to-out_valid for LANES=4.
// Backpressure: holds out_ready low in DONE and checks the result stays put.
module tb_prince_affine_layer_masked;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    prince_affine_layer_masked_if #(.NSHARES(2)) ifn ();
    prince_affine_layer_masked_if #(.NSHARES(2)) ifr ();

    prince_affine_layer_masked #(.NSHARES(2), .LANES(4), .REFRESH(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifn)
    );

    prince_affine_layer_masked #(.NSHARES(2), .LANES(4), .REFRESH(1)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference affine map on the unmasked value, written from the share-0 bit equations.
    function automatic logic [63:0] aff(input logic [63:0] x, input bit md);
        logic [63:0] r;
        logic [3:0]  s;
        logic [3:0]  o;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            s = x[4*i +: 4];
            if (!md) begin
                o[0] = ~s[1];
                o[1] = s[0] ^ s[1] ^ s[2];
                o[2] = ~s[3];
                o[3] = s[2];
            end else begin
                o[0] = ~(s[0] ^ s[1] ^ s[3]);
                o[1] = ~s[0];
                o[2] = s[3];
                o[3] = ~s[2];
            end
            r[4*i +: 4] = o;
        end
        return r;
    endfunction

    task automatic drive(input bit use_r, input bit v, input bit md,
                         input logic [127:0] st, input logic [63:0] rn);
        if (use_r) begin
            ifr.in_valid = v; ifr.mode_i = md; ifr.state_i = st; ifr.rnd_i = rn;
        end else begin
            ifn.in_valid = v; ifn.mode_i = md; ifn.state_i = st; ifn.rnd_i = rn;
        end
    endtask

    // One transaction: handshake, wait (bounded) for out_valid, optionally let it be consumed.
    task automatic run_txn(input bit use_r, input bit md, input logic [127:0] st,
                           input logic [63:0] rn, input bit consume,
                           output logic [127:0] res, output int lat);
        logic vld;
        lat = -1;
        res = '0;
        @(negedge clk);
        drive(use_r, 1'b1, md, st, rn);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) drive(use_r, 1'b0, md, st, rn);
            vld = use_r ? ifr.out_valid : ifn.out_valid;
            if (vld) begin
                lat = c;
                res = use_r ? ifr.state_o : ifn.state_o;
                break;
            end
        end
        if (consume) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] res2;
        logic [127:0] held;
        logic [127:0] st;
        logic [63:0]  x;
        logic [63:0]  m;
        logic [63:0]  rn;
        int           lat;
        bit           stable;
        bit           rdy_low;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        ifn.out_ready = 1'b1;
        ifr.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'd0, ifn.out_valid}, 128'd0);
        chk("rst_state_o", ifn.state_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {127'd0, ifn.in_ready}, 128'd1);

        // A on all-zero shares
        run_txn(1'b0, 1'b0, 128'd0, 64'd0, 1'b1, res, lat);
        chk("a_zero_lat", 128'(lat), 128'd5);
        chk("a_zero", res, {64'h0, 64'h5555_5555_5555_5555});

        // A^-1 on all-zero shares
        run_txn(1'b0, 1'b1, 128'd0, 64'd0, 1'b1, res, lat);
        chk("ainv_zero_lat", 128'(lat), 128'd5);
        chk("ainv_zero", res, {64'h0, 64'hBBBB_BBBB_BBBB_BBBB});

        // A on all-ones share 0
        run_txn(1'b0, 1'b0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd0, 1'b1, res, lat);
        chk("a_ones", res, {64'h0, 64'hAAAA_AAAA_AAAA_AAAA});

        // Distinct nibbles: checks lane ordering in share 0 and in share 1
        run_txn(1'b0, 1'b0, {64'h0, 64'h0123_4567_89AB_CDEF}, 64'd0, 1'b1, res, lat);
        chk("a_seq_sh0", res, {64'h0, 64'h5764_FDCE_1320_B98A});
        run_txn(1'b0, 1'b0, {64'h0123_4567_89AB_CDEF, 64'h0}, 64'd0, 1'b1, res, lat);
        chk("a_seq_sh1", res, {64'h0231_A89B_4675_ECDF, 64'h5555_5555_5555_5555});

        // Re-masking instance: zero input, fixed mask
        run_txn(1'b1, 1'b0, 128'd0, 64'h0123_4567_89AB_CDEF, 1'b1, res, lat);
        chk("refresh_lat", 128'(lat), 128'd5);
        chk("refresh_sh1", {64'h0, res[127:64]}, {64'h0, 64'h0231_A89B_4675_ECDF});
        chk("refresh_xor", {64'h0, res[127:64] ^ res[63:0]}, {64'h0, 64'h5555_5555_5555_5555});

        // Back-pressure: result held in DONE while out_ready is low
        ifn.out_ready = 1'b0;
        run_txn(1'b0, 1'b1, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd0, 1'b0, held, lat);
        chk("bp_lat", 128'(lat), 128'd5);
        stable  = 1'b1;
        rdy_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (ifn.state_o !== held || ifn.out_valid !== 1'b1) stable = 1'b0;
            if (ifn.in_ready !== 1'b0) rdy_low = 1'b0;
        end
        chk("bp_stable", {127'd0, stable}, 128'd1);
        chk("bp_in_ready_low", {127'd0, rdy_low}, 128'd1);
        chk("bp_value", held, {64'h0, aff(64'hFFFF_FFFF_FFFF_FFFF, 1'b1)});
        @(negedge clk);
        ifn.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {127'd0, ifn.in_ready}, 128'd1);
        chk("bp_release_out_valid", {127'd0, ifn.out_valid}, 128'd0);

        // Reset asserted in the second BUSY cycle
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, {64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000}, 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {127'd0, ifn.out_valid}, 128'd0);
        chk("midrst_state_o", ifn.state_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {127'd0, ifn.in_ready}, 128'd1);
        run_txn(1'b0, 1'b0, 128'd0, 64'd0, 1'b1, res, lat);
        chk("midrst_relaunch_lat", 128'(lat), 128'd5);
        chk("midrst_relaunch", res, {64'h0, 64'h5555_5555_5555_5555});

        // Random masked vectors: XOR of output shares equals the affine map of the secret
        for (int i = 0; i < 1000; i++) begin
            x  = {$urandom, $urandom};
            m  = {$urandom, $urandom};
            rn = {$urandom, $urandom};
            st = {m, x ^ m};
            run_txn(i[1], i[0], st, rn, 1'b1, res, lat);
            chk("rand_xor", {64'h0, res[127:64] ^ res[63:0]}, {64'h0, aff(x, i[0])});
        end

        // A^-1(A(x)) = x through two masked passes
        for (int i = 0; i < 100; i++) begin
            x  = {$urandom, $urandom};
            m  = {$urandom, $urandom};
            run_txn(1'b0, 1'b0, {m, x ^ m}, 64'd0, 1'b1, res, lat);
            run_txn(1'b0, 1'b1, res, 64'd0, 1'b1, res2, lat);
            chk("inv_roundtrip", {64'h0, res2[127:64] ^ res2[63:0]}, {64'h0, x});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
